mul_result_buffer: RTL and testbench

Downstream companion of the pipelined multiplier. The multiplier carries no destination tags and has no backpressure.
- This block gates issue into the multiplier and tracks each op's destination tag through the fixed multiplier latency.
- It captures each result with its tag into a small in-order FIFO and presents it to writeback with a valid/ready handshake.
- Source operands and opcode go from the issue stage straight to the multiplier; only the multiplier's valid is driven from here.

---
 rtl/mul_result_buffer_pkg.sv | 19 +
 rtl/mul_result_buffer_fifo.sv | 60 ++++++
 rtl/mul_result_buffer.sv | 111 +++++++++++
 tb/tb_mul_result_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// mul_result_buffer_pkg
// Shared constants and the buffered entry type for the multiplier result buffer.
// Revision: 1.0
// ============================================================================
package mul_result_buffer_pkg;

    localparam int MUL_LAT_DEF = 2;
    localparam int REG_TAG_W   = 5;
    localparam int DATA_W      = 32;

    typedef struct packed {
        logic [REG_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/mul_result_buffer_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo_flush
// In-order circular FIFO with single-cycle flush and async reset.
// Revision: 1.0
// ============================================================================
module sync_fifo_flush #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 37,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mul_result_buffer.sv
`default_nettype none
// ============================================================================
// mul_result_buffer
// Gates multiplier issue by credits, tracks destination tags through the fixed
// multiplier latency and buffers tagged results for writeback.
// Revision: 1.0
// ============================================================================
module mul_result_buffer
    import mul_result_buffer_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TAG_W   = REG_TAG_W,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_rd,
    output logic             mul_valid,
    input  logic             mul_ok,
    input  logic [31:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_rd,
    output logic [31:0]      out_result
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = 8;
    localparam int ENT_W = TAG_W + 32;

    logic [MUL_LAT-1:0]            tag_v;
    logic [MUL_LAT-1:0]            tag_v_next;
    logic [MUL_LAT-1:0][TAG_W-1:0] tag_rd;
    logic [MUL_LAT-1:0][TAG_W-1:0] tag_rd_next;
    logic [SUM_W-1:0]              inflight;
    logic [SUM_W-1:0]              used;
    logic [CNT_W-1:0]              occ;
    logic [ENT_W-1:0]              head;
    logic [ENT_W-1:0]              out_entry;
    logic                          fire;
    logic                          capture;
    logic                          pop;

    // Credits count both in-flight and buffered ops so a capture never overflows.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            if (tag_v[i]) inflight = inflight + 1'b1;
        end
    end

    assign used      = inflight + SUM_W'(occ);
    assign in_ready  = (used < SUM_W'(DEPTH)) & ~flush;
    assign fire      = in_valid & in_ready;
    assign mul_valid = fire;

    always_comb begin
        tag_v_next     = tag_v << 1;
        tag_v_next[0]  = fire;
        tag_rd_next    = tag_rd << TAG_W;
        tag_rd_next[0] = in_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
        end else if (flush) begin
            tag_v <= '0;
        end else begin
            tag_v <= tag_v_next;
        end
    end

    always_ff @(posedge clk) begin
        tag_rd <= tag_rd_next;
    end

    // Results without a live tag (flushed or pre-reset ops) are dropped here.
    assign capture = mul_ok & tag_v[MUL_LAT-1] & ~flush;
    assign pop     = out_valid & out_ready & ~flush;

    sync_fifo_flush #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (capture),
        .push_data ({tag_rd[MUL_LAT-1], mul_result}),
        .pop       (pop),
        .count     (occ),
        .head      (head)
    );

    assign out_valid  = (occ != '0);
    assign out_entry  = out_valid ? head : '0;
    assign out_rd     = out_entry[ENT_W-1:32];
    assign out_result = out_entry[31:0];

`ifndef SYNTHESIS
    a_result_arrives: assert property (@(posedge clk) disable iff (reset)
        tag_v[MUL_LAT-1] |-> mul_ok)
        else $error("mul_result_buffer: multiplier result missing for tracked op");
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_result_buffer.sv
`default_nettype none
// ============================================================================
// tb_mul_result_buffer
// Scoreboard bench with a fixed-latency multiplier model driving mul_ok.
// Revision: 1.0
// ============================================================================
module tb_mul_result_buffer;
    import mul_result_buffer_pkg::*;

    localparam int DEPTH = 2;
    localparam int TAG_W = REG_TAG_W;
    localparam int LAT   = MUL_LAT_DEF;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_rd;
    logic             mul_valid;
    logic             mul_ok;
    logic [31:0]      mul_result;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_rd;
    logic [31:0]      out_result;

    always #5 clk = ~clk;

    mul_result_buffer #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .MUL_LAT (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .mul_valid  (mul_valid),
        .mul_ok     (mul_ok),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    entry_t      sb[$];
    bit          pipe_v[LAT];
    bit          sched_ok[1024];
    logic [31:0] sched_res[1024];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int inflight_cnt();
        int n = 0;
        for (int i = 0; i < LAT; i++) n += int'(pipe_v[i]);
        return n;
    endfunction

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check after settling, then advance the model.
    task automatic cycle(input bit inv, input logic [TAG_W-1:0] rd, input logic [31:0] res,
                         input bit ordy, input bit fl);
        bit exp_rdy;
        bit exp_ov;
        bit fire;
        bit pop;
        int buffered;
        @(negedge clk);
        cyc++;
        in_valid   = inv;
        in_rd      = rd;
        out_ready  = ordy;
        flush      = fl;
        mul_ok     = sched_ok[cyc];
        mul_result = sched_res[cyc];
        #1;
        buffered = sb.size() - inflight_cnt();
        exp_rdy  = (inflight_cnt() + buffered < DEPTH) && !fl;
        exp_ov   = buffered > 0;
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        check_eq("mul_valid", 64'(mul_valid), 64'(inv && exp_rdy));
        check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
        fire = inv && exp_rdy;
        pop  = exp_ov && ordy && !fl;
        if (pop) begin
            check_eq("out_rd", 64'(out_rd), 64'(sb[0].tag));
            check_eq("out_result", 64'(out_result), 64'(sb[0].data));
        end
        if (mul_valid) begin
            sched_ok[cyc + LAT]  = 1'b1;
            sched_res[cyc + LAT] = res;
        end
        if (fl) begin
            model_clear();
        end else begin
            if (pop) void'(sb.pop_front());
            for (int i = LAT - 1; i > 0; i--) pipe_v[i] = pipe_v[i-1];
            pipe_v[0] = fire;
            if (fire) sb.push_back('{tag: rd, data: res});
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, ordy, 1'b0);
    endtask

    // Async reset pulse inside one cycle; the in-flight result lands after release.
    task automatic reset_mid();
        @(negedge clk);
        cyc++;
        in_valid   = 1'b0;
        in_rd      = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        mul_ok     = sched_ok[cyc];
        mul_result = sched_res[cyc];
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_rd", 64'(out_rd), 64'd0);
        check_eq("rst_out_result", 64'(out_result), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        model_clear();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_rd      = '0;
        out_ready  = 1'b0;
        mul_ok     = 1'b0;
        mul_result = '0;
        for (int i = 0; i < 1024; i++) begin
            sched_ok[i]  = 1'b0;
            sched_res[i] = '0;
        end
        model_clear();
        #1;
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_mul_valid", 64'(mul_valid), 64'd0);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_out_rd", 64'(out_rd), 64'd0);
        check_eq("reset_out_result", 64'(out_result), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single op: issue rd=5, result 0xC, popped as soon as it appears.
        cycle(1'b1, 5'd5, 32'h0000_000C, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Backpressure with stalled writeback, then one pop frees a credit.
        cycle(1'b1, 5'd1, 32'h1111_0001, 1'b0, 1'b0);
        cycle(1'b1, 5'd2, 32'h2222_0002, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'd3, 32'h3333_0003, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 32'h3333_0003, 1'b1, 1'b0);
        cycle(1'b1, 5'd3, 32'h3333_0003, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Flush one cycle after issue: the result is dropped.
        cycle(1'b1, 5'd7, 32'h7777_0007, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Simultaneous push and pop with one entry buffered.
        cycle(1'b1, 5'd4, 32'h4444_0004, 1'b0, 1'b0);
        cycle(1'b1, 5'd6, 32'h6666_0006, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Async reset with one op buffered and one in flight.
        cycle(1'b1, 5'd8, 32'h8888_0008, 1'b0, 1'b0);
        cycle(1'b1, 5'd9, 32'h9999_0009, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        reset_mid();
        idle(4, 1'b1);

        // Flush coincident with an offer and a pending pop, then resume.
        cycle(1'b1, 5'd10, 32'hAAAA_000A, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 5'd11, 32'hBBBB_000B, 1'b1, 1'b1);
        cycle(1'b1, 5'd12, 32'hCCCC_000C, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        idle(6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
